// File: rtl/array_ex_pkg.sv
// Shared definitions for the array_ex register array: default sizes,
// bus word/address types and the {sel, wr} access-decode encoding.
package array_ex_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned ADDR_W_DEF = 2;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // Access type, encoded as {sel, wr}; any code with sel=0 is idle.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] READ  = 2'b10;
    localparam logic [1:0] WRITE = 2'b11;

    // Collapse {sel, wr} onto IDLE/READ/WRITE so wr is ignored when deselected.
    function automatic logic [1:0] access_decode(input logic sel, input logic wr);
        return sel ? {1'b1, wr} : IDLE;
    endfunction

endpackage : array_ex_pkg

// File: rtl/array_ex.sv
// Single-port synchronous register array, DEPTH words of DATA_W bits.
// Ports:
//   clk   - system clock, rising-edge active
//   rst   - asynchronous active-low reset; clears every word and rdata
//   addr  - word address of the current access
//   wr    - 1 = write, 0 = read; only meaningful while sel=1
//   sel   - block select; no access when 0
//   wdata - write data
//   rdata - registered read data, one-cycle latency, held between reads
module array_ex
    import array_ex_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic              sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [1:0]        acc_c;
    logic [DATA_W-1:0] mem_c [DEPTH];

    assign acc_c = access_decode(sel, wr);

    // One storage word per address, each with its own decoded write enable.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic              we_c;
        logic [DATA_W-1:0] word_q;

        assign we_c = (acc_c == WRITE) && (addr == ADDR_W'(i));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                word_q <= '0;
            end else if (we_c) begin
                word_q <= wdata;
            end
        end

        assign mem_c[i] = word_q;
    end

    // Read register: loads only on a selected read, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (acc_c == READ) begin
            rdata <= mem_c[addr];
        end
    end

`ifndef SYNTHESIS
    // Geometry sanity check at elaboration.
    if ((ADDR_W != $clog2(DEPTH)) || (DEPTH < 2)) begin : g_bad_geometry
        $error("array_ex: ADDR_W must equal log2(DEPTH) and DEPTH must be >= 2");
    end

    // Read data is cleared while reset is held.
    a_rdata_reset: assert property (@(posedge clk) !rst |-> (rdata == '0));

    // No word can take a write while reset is held.
    for (genvar i = 0; i < DEPTH; i++) begin : g_chk_word
        a_no_write_in_reset: assert property (@(posedge clk) !rst |-> (g_word[i].word_q == '0));
    end
`endif

endmodule : array_ex

// File: tb/tb_array_ex.sv
// Self-checking bench for array_ex: directed vector table, an async-reset
// sequence, then randomized traffic checked against a behavioural model.
module tb_array_ex;
    import array_ex_pkg::*;

    logic  clk;
    logic  rst;
    addr_t addr;
    logic  wr;
    logic  sel;
    word_t wdata;
    word_t rdata;

    int n_tests = 0;
    int n_fail  = 0;

    array_ex dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wr    (wr),
        .sel   (sel),
        .wdata (wdata),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  rst;
        logic  sel;
        logic  wr;
        addr_t addr;
        word_t wdata;
        word_t exp;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: rdata=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic w, input addr_t a,
                       input word_t d, input word_t e, input string n);
        vec_t v;
        v.rst = r; v.sel = s; v.wr = w; v.addr = a; v.wdata = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    // Behavioural model state for the random phase.
    word_t model_mem [4];
    word_t model_rd;

    initial begin
        rst = 1'b0; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

        // Test 1: write during reset is ignored.
        add(1'b0, 1'b1, 1'b1, 2'd0, 16'hABCD, 16'h0000, "t1_write_in_reset");
        add(1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, "t1_read0_after_reset");
        // Test 2: write then read back.
        add(1'b1, 1'b1, 1'b1, 2'd1, 16'hABCD, 16'h0000, "t2_write1_rdata_holds");
        add(1'b1, 1'b1, 1'b0, 2'd1, 16'h0000, 16'hABCD, "t2_read1");
        // Test 3: unwritten words.
        add(1'b1, 1'b1, 1'b0, 2'd2, 16'h0000, 16'h0000, "t3_read2");
        add(1'b1, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h0000, "t3_read3");
        add(1'b1, 1'b1, 1'b0, 2'd1, 16'h0000, 16'hABCD, "t3_read1");
        // Test 4: address independence.
        add(1'b1, 1'b1, 1'b1, 2'd0, 16'h1111, 16'hABCD, "t4_write0");
        add(1'b1, 1'b1, 1'b1, 2'd1, 16'h2222, 16'hABCD, "t4_write1");
        add(1'b1, 1'b1, 1'b1, 2'd2, 16'h3333, 16'hABCD, "t4_write2");
        add(1'b1, 1'b1, 1'b1, 2'd3, 16'h4444, 16'hABCD, "t4_write3");
        add(1'b1, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h4444, "t4_read3");
        add(1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 16'h1111, "t4_read0");
        add(1'b1, 1'b1, 1'b0, 2'd2, 16'h0000, 16'h3333, "t4_read2");
        add(1'b1, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h2222, "t4_read1");
        // Test 5: select gating, rdata holds and memory is untouched.
        for (int a = 0; a < 4; a++) begin
            add(1'b1, 1'b0, 1'b1, addr_t'(a), 16'hFFFF, 16'h2222, "t5_idle_wr1");
            add(1'b1, 1'b0, 1'b0, addr_t'(a), 16'hFFFF, 16'h2222, "t5_idle_wr0");
        end
        add(1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 16'h1111, "t5_read0");
        add(1'b1, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h2222, "t5_read1");
        add(1'b1, 1'b1, 1'b0, 2'd2, 16'h0000, 16'h3333, "t5_read2");
        add(1'b1, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h4444, "t5_read3");

        #1;
        check("reset_initial", rdata, 16'h0000);

        // Inputs change #1 after each rising edge; results sampled there too.
        foreach (vecs[i]) begin
            rst = vecs[i].rst; sel = vecs[i].sel; wr = vecs[i].wr;
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            @(posedge clk);
            #1;
            check(vecs[i].name, rdata, vecs[i].exp);
        end

        // Test 6: async reset between edges clears rdata immediately.
        sel = 1'b0; wr = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_reset_rdata", rdata, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            sel = 1'b1; wr = 1'b0; addr = addr_t'(a);
            @(posedge clk);
            #1;
            check($sformatf("t6_read%0d_after_reset", a), rdata, 16'h0000);
        end

        // Random phase against a behavioural model (array starts cleared).
        foreach (model_mem[k]) model_mem[k] = '0;
        model_rd = '0;
        for (int c = 0; c < 400; c++) begin
            sel   = ($urandom_range(0, 3) != 0);
            wr    = $urandom_range(0, 1) != 0;
            addr  = addr_t'($urandom_range(0, 3));
            wdata = word_t'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                // Short reset pulse between edges wipes the whole array.
                rst = 1'b0;
                #1;
                check("rand_async_reset", rdata, 16'h0000);
                rst = 1'b1;
                foreach (model_mem[k]) model_mem[k] = '0;
                model_rd = '0;
            end
            if (sel && wr) model_mem[addr] = wdata;
            else if (sel)  model_rd = model_mem[addr];
            @(posedge clk);
            #1;
            check("rand", rdata, model_rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_array_ex

// File: doc/array_ex.md
Name: array_ex

Overview:
- Small single-port synchronous register array: DEPTH words of DATA_W bits, addressed by `addr`.
- The block is active only when `sel` is high; `wr` chooses write (1) or read (0).
- Used as a scratch/config storage element behind a simple chip-select bus.
- Read data is registered: it appears one clock after the read request and is held until the next read.

Parameters:
- DATA_W, 16, width of each stored word and of the `wdata`/`rdata` buses.
- DEPTH, 4, number of words; must be a power of two and at least 2.
- ADDR_W, 2, address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- addr  input  ADDR_W  word address for the current access.
- wr  input  1  1 = write access, 0 = read access; qualified by `sel`.
- sel  input  1  block select; no access occurs when 0.
- wdata  input  DATA_W  write data, sampled on the rising edge when `sel`=1 and `wr`=1.
- rdata  output  DATA_W  registered read data.

Behaviour:
- Reset (`rst`=0):
  - Immediately, without waiting for a clock edge, clears all DEPTH words and `rdata` to 0.
  - While reset is held, every access is ignored, including writes.
- Reset release: a deassertion coincident with a clock edge does not perform the access on that edge; the first access is taken on the next rising edge.
- Write (`sel`=1, `wr`=1) at a rising edge:
  - mem[addr] <= wdata.
  - `rdata` is unchanged.
  - Data is visible to a read issued on the following cycle.
- Read (`sel`=1, `wr`=0) at a rising edge:
  - rdata <= mem[addr].
  - One-cycle latency.
  - Memory is unchanged.
- Idle (`sel`=0): memory and `rdata` both hold, regardless of `wr`, `addr` and `wdata`.
- Read-during-write: impossible by construction, because `wr` selects exactly one operation per cycle.
- Read after write to the same address on consecutive cycles returns the newly written value, with no bypass needed.
- Address range:
  - Every `addr` value is legal, since DEPTH = 2^ADDR_W.
  - There is no wrap or out-of-range handling.
- Unwritten words read as 0 after reset.
- X/Z on `addr` or `wdata` while `sel`=0 has no effect.
- No handshake, no stall and no error output: every selected access completes in one cycle.

Decomposition:
- Shared package `array_ex_pkg` holds:
  - Constants: DATA_W_DEF=16, DEPTH_DEF=4, ADDR_W_DEF=2.
  - Typedefs: `word_t` (logic [DATA_W-1:0]) and `addr_t` (logic [ADDR_W-1:0]).
  - Localparams for the access-decode encoding: IDLE, WRITE, READ, derived from {sel, wr}.
- No sub-module: the storage array, write decode and read register stay in one module.
- The write enable is a per-word generated decode.
- Include an assertion block (simulation only) checking:
  - ADDR_W == $clog2(DEPTH);
  - `rdata` is 0 after reset;
  - no write occurs while `rst`=0.

Test Plan:
1. Reset and write gating: hold `rst`=0 with sel=1, wr=1, addr=0, wdata=16'hABCD for one cycle, then release and read addr 0 -> rdata=16'h0000 (the write during reset is ignored).
2. Write then read back: after reset, write 16'hABCD to addr 1, then read addr 1 -> rdata=16'hABCD one cycle after the read edge.
3. Unwritten words: after test 2, read addr 2 and then addr 3 -> rdata=16'h0000 for each; then read addr 1 -> 16'hABCD.
4. Address independence: write 16'h1111, 16'h2222, 16'h3333 and 16'h4444 to addr 0 through 3, then read in the order 3, 0, 2, 1 -> 4444, 1111, 3333, 2222.
5. Select gating: with sel=0, toggle wr and drive wdata=16'hFFFF on every address -> memory unchanged and `rdata` holds its last read value.
6. Async reset mid-operation: pull `rst` low between clock edges after test 4 -> `rdata`=0 immediately (before the next edge); after release, every address reads 0.
